// File: rtl/motor_move_ctrl_if.sv
// Command and status bundle between a move requester and motor_move_ctrl.
interface motor_move_ctrl_if;
  localparam int unsigned CW = 16;

  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_dir;
  logic          cmd_full;
  logic [CW-1:0] cmd_steps;
  logic [CW-1:0] cmd_period;
  logic          abort;
  logic          step_pulse;
  logic          direction;
  logic          step;
  logic          busy;
  logic          done;
  logic [CW-1:0] steps_left;

  // Requester side: issues commands and abort, observes progress.
  modport master (
    output cmd_valid, cmd_dir, cmd_full, cmd_steps, cmd_period, abort,
    input  cmd_ready, step_pulse, direction, step, busy, done, steps_left
  );

  // Controller side.
  modport slave (
    input  cmd_valid, cmd_dir, cmd_full, cmd_steps, cmd_period, abort,
    output cmd_ready, step_pulse, direction, step, busy, done, steps_left
  );
endinterface

// File: rtl/motor_move_ctrl.sv
// Trapezoidal step-rate generator: ramps the step interval from START_PERIOD
// down to the commanded cruise interval and back, issuing one strobe per step.
module motor_move_ctrl #(
  parameter logic [15:0] START_PERIOD = 16'd1000,
  parameter logic [15:0] ACCEL_DEC    = 16'd50,
  parameter logic [15:0] MIN_PERIOD   = 16'd2
) (
  input  logic             clk,
  input  logic             nrst,
  motor_move_ctrl_if.slave bus
);
  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEL  = 2'd1,
    CRUISE = 2'd2,
    DECEL  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] timer, timer_nxt;
  logic [CW-1:0] cur_period, cur_period_nxt;
  logic [CW-1:0] target, target_nxt;
  logic [CW-1:0] accel_steps, accel_steps_nxt;
  logic [CW-1:0] steps_left, steps_left_nxt;
  logic          direction, direction_nxt;
  logic          step, step_nxt;
  logic          done, done_nxt;
  logic          reload;

  logic          busy_c;
  logic          accept;
  logic [CW-1:0] tgt_c;
  logic [CW-1:0] steps_dec;
  logic [CW-1:0] acc_inc;
  logic [CW-1:0] acc_dec;
  logic [CW-1:0] cur_dn;
  logic [CW-1:0] cur_up_sat;
  logic [CW:0]   cur_up;
  logic [CW:0]   ramp_floor;

  // Shared arithmetic; 17-bit sums keep the ramp comparisons free of wrap.
  assign busy_c     = (state != IDLE);
  assign accept     = bus.cmd_valid && (state == IDLE);
  assign tgt_c      = (bus.cmd_period < MIN_PERIOD) ? MIN_PERIOD : bus.cmd_period;
  assign steps_dec  = (steps_left == '0) ? '0 : steps_left - CW'(1);
  assign acc_inc    = accel_steps + CW'(1);
  assign acc_dec    = (accel_steps == '0) ? '0 : accel_steps - CW'(1);
  assign cur_dn     = cur_period - ACCEL_DEC;
  assign cur_up     = {1'b0, cur_period} + {1'b0, ACCEL_DEC};
  assign cur_up_sat = (cur_up >= {1'b0, START_PERIOD}) ? START_PERIOD : cur_up[CW-1:0];
  assign ramp_floor = {1'b0, target} + {1'b0, ACCEL_DEC};

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and datapath updates: accept, interval timing, ramp profile, abort.
  always_comb begin
    state_nxt       = state;
    timer_nxt       = timer;
    cur_period_nxt  = cur_period;
    target_nxt      = target;
    accel_steps_nxt = accel_steps;
    steps_left_nxt  = steps_left;
    direction_nxt   = direction;
    step_nxt        = step;
    done_nxt        = 1'b0;
    reload          = 1'b0;

    if (state == IDLE) begin
      if (accept) begin
        direction_nxt   = bus.cmd_dir;
        step_nxt        = bus.cmd_full;
        steps_left_nxt  = bus.cmd_steps;
        target_nxt      = tgt_c;
        accel_steps_nxt = '0;
        if (bus.cmd_steps == '0) begin
          done_nxt = 1'b1;
        end else if (tgt_c >= START_PERIOD) begin
          cur_period_nxt = tgt_c;
          state_nxt      = CRUISE;
          reload         = 1'b1;
        end else begin
          cur_period_nxt = START_PERIOD;
          state_nxt      = ACCEL;
          reload         = 1'b1;
        end
      end
    end else if (bus.abort) begin
      state_nxt = IDLE;
      done_nxt  = 1'b1;
    end else if (timer != '0) begin
      timer_nxt = timer - CW'(1);
    end else begin
      steps_left_nxt = steps_dec;
      reload         = 1'b1;
      if (steps_dec == '0) begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end else begin
        case (state)
          ACCEL: begin
            accel_steps_nxt = acc_inc;
            if (steps_dec <= acc_inc) begin
              state_nxt = DECEL;
            end else if ({1'b0, cur_period} <= ramp_floor) begin
              cur_period_nxt = target;
              state_nxt      = CRUISE;
            end else begin
              cur_period_nxt = cur_dn;
            end
          end
          CRUISE: begin
            if (steps_dec <= accel_steps) begin
              state_nxt       = DECEL;
              cur_period_nxt  = cur_up_sat;
              accel_steps_nxt = acc_dec;
            end
          end
          DECEL: begin
            cur_period_nxt  = cur_up_sat;
            accel_steps_nxt = acc_dec;
          end
          default: ;
        endcase
      end
    end

    if (reload) timer_nxt = cur_period_nxt - CW'(1);
  end

  // Outputs decoded from state; a strobe due in an abort cycle is dropped.
  always_comb begin
    bus.cmd_ready  = nrst && (state == IDLE);
    bus.busy       = busy_c;
    bus.step_pulse = busy_c && (timer == '0) && !bus.abort;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      timer       <= '0;
      cur_period  <= '0;
      target      <= '0;
      accel_steps <= '0;
      steps_left  <= '0;
      direction   <= 1'b0;
      step        <= 1'b1;
      done        <= 1'b0;
    end else begin
      timer       <= timer_nxt;
      cur_period  <= cur_period_nxt;
      target      <= target_nxt;
      accel_steps <= accel_steps_nxt;
      steps_left  <= steps_left_nxt;
      direction   <= direction_nxt;
      step        <= step_nxt;
      done        <= done_nxt;
    end
  end

  assign bus.direction  = direction;
  assign bus.step       = step;
  assign bus.done       = done;
  assign bus.steps_left = steps_left;
endmodule

// File: tb/tb_motor_move_ctrl.sv
// Self-checking bench for motor_move_ctrl with a small ramp (10 / 3 / 2).
module tb_motor_move_ctrl;
  logic clk  = 1'b0;
  logic nrst = 1'b1;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  int exp_pulse_q[$];
  int exp_done_q[$];
  int obs_pulse_q[$];
  int obs_done_q[$];

  motor_move_ctrl_if bus();

  motor_move_ctrl #(
    .START_PERIOD(16'd10),
    .ACCEL_DEC   (16'd3),
    .MIN_PERIOD  (16'd2)
  ) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus)
  );

  // Clock and cycle index.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record the cycle of every strobe and done seen on the DUT.
  always @(negedge clk) begin
    if (bus.step_pulse === 1'b1) obs_pulse_q.push_back(cyc);
    if (bus.done === 1'b1)       obs_done_q.push_back(cyc);
  end

  // Offer one command and return the cycle in which it was accepted (-1 on timeout).
  task automatic send(input logic d, input logic f, input logic [15:0] s,
                      input logic [15:0] p, output int acc);
    @(posedge clk); #1;
    bus.cmd_valid  = 1'b1;
    bus.cmd_dir    = d;
    bus.cmd_full   = f;
    bus.cmd_steps  = s;
    bus.cmd_period = p;
    acc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.cmd_ready === 1'b1) begin
        acc = cyc;
        break;
      end
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  // Advance until done is seen or the budget runs out.
  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) break;
    end
    #1;
  endtask

  task automatic test_reset();
    #2 nrst = 1'b0;
    #1;
    n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", bus.cmd_ready); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0 || bus.step_pulse !== 1'b0) begin n_bad++; $display("FAIL rst_strobes: done %b pulse %b want 0 0", bus.done, bus.step_pulse); end
    n_cmp++; if (bus.direction !== 1'b0 || bus.step !== 1'b1) begin n_bad++; $display("FAIL rst_latch: dir %b step %b want 0 1", bus.direction, bus.step); end
    n_cmp++; if (bus.steps_left !== 16'd0) begin n_bad++; $display("FAIL rst_steps: got %0d want 0", bus.steps_left); end
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    #1;
    n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b want 1", bus.cmd_ready); end
  endtask

  task automatic test_cruise();
    int acc, e, o;
    obs_pulse_q.delete(); obs_done_q.delete();
    send(1'b1, 1'b1, 16'd3, 16'd12, acc);
    exp_pulse_q.push_back(acc + 12);
    exp_pulse_q.push_back(acc + 24);
    exp_pulse_q.push_back(acc + 36);
    exp_done_q.push_back(acc + 37);
    n_cmp++; if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL cruise_busy: busy %b ready %b want 1 0", bus.busy, bus.cmd_ready); end
    n_cmp++; if (bus.direction !== 1'b1 || bus.step !== 1'b1 || bus.steps_left !== 16'd3) begin n_bad++; $display("FAIL cruise_latch: dir %b step %b left %0d want 1 1 3", bus.direction, bus.step, bus.steps_left); end
    wait_done(100);
    n_cmp++; if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.steps_left !== 16'd0) begin n_bad++; $display("FAIL cruise_end: busy %b ready %b left %0d want 0 1 0", bus.busy, bus.cmd_ready, bus.steps_left); end
    while (exp_pulse_q.size() > 0) begin
      e = exp_pulse_q.pop_front(); o = (obs_pulse_q.size() > 0) ? obs_pulse_q.pop_front() : -1;
      n_cmp++; if (o != e) begin n_bad++; $display("FAIL cruise_pulse: cycle %0d want %0d", o, e); end
    end
    while (exp_done_q.size() > 0) begin
      e = exp_done_q.pop_front(); o = (obs_done_q.size() > 0) ? obs_done_q.pop_front() : -1;
      n_cmp++; if (o != e) begin n_bad++; $display("FAIL cruise_done: cycle %0d want %0d", o, e); end
    end
    n_cmp++; if (obs_pulse_q.size() + obs_done_q.size() != 0) begin n_bad++; $display("FAIL cruise_extra: %0d extra events want 0", obs_pulse_q.size() + obs_done_q.size()); end
  endtask

  task automatic test_trapezoid();
    int acc, t, e, o;
    int iv[6] = '{10, 7, 4, 4, 7, 10};
    obs_pulse_q.delete(); obs_done_q.delete();
    send(1'b0, 1'b0, 16'd6, 16'd4, acc);
    t = acc;
    foreach (iv[i]) begin t += iv[i]; exp_pulse_q.push_back(t); end
    exp_done_q.push_back(t + 1);
    n_cmp++; if (bus.direction !== 1'b0 || bus.step !== 1'b0) begin n_bad++; $display("FAIL trap_latch: dir %b step %b want 0 0", bus.direction, bus.step); end
    wait_done(100);
    while (exp_pulse_q.size() > 0) begin
      e = exp_pulse_q.pop_front(); o = (obs_pulse_q.size() > 0) ? obs_pulse_q.pop_front() : -1;
      n_cmp++; if (o != e) begin n_bad++; $display("FAIL trap_pulse: cycle %0d want %0d", o, e); end
    end
    while (exp_done_q.size() > 0) begin
      e = exp_done_q.pop_front(); o = (obs_done_q.size() > 0) ? obs_done_q.pop_front() : -1;
      n_cmp++; if (o != e) begin n_bad++; $display("FAIL trap_done: cycle %0d want %0d", o, e); end
    end
    n_cmp++; if (obs_pulse_q.size() + obs_done_q.size() != 0) begin n_bad++; $display("FAIL trap_extra: %0d extra events want 0", obs_pulse_q.size() + obs_done_q.size()); end
  endtask

  task automatic test_triangle();
    int acc, t, e, o;
    int iv[4] = '{10, 7, 7, 10};
    obs_pulse_q.delete(); obs_done_q.delete();
    send(1'b1, 1'b1, 16'd4, 16'd2, acc);
    t = acc;
    foreach (iv[i]) begin t += iv[i]; exp_pulse_q.push_back(t); end
    exp_done_q.push_back(t + 1);
    wait_done(100);
    while (exp_pulse_q.size() > 0) begin
      e = exp_pulse_q.pop_front(); o = (obs_pulse_q.size() > 0) ? obs_pulse_q.pop_front() : -1;
      n_cmp++; if (o != e) begin n_bad++; $display("FAIL tri_pulse: cycle %0d want %0d", o, e); end
    end
    while (exp_done_q.size() > 0) begin
      e = exp_done_q.pop_front(); o = (obs_done_q.size() > 0) ? obs_done_q.pop_front() : -1;
      n_cmp++; if (o != e) begin n_bad++; $display("FAIL tri_done: cycle %0d want %0d", o, e); end
    end
    n_cmp++; if (obs_pulse_q.size() + obs_done_q.size() != 0) begin n_bad++; $display("FAIL tri_extra: %0d extra events want 0", obs_pulse_q.size() + obs_done_q.size()); end
  endtask

  // Period 0 is raised to MIN_PERIOD; the ramp clamps there and saturates at START_PERIOD.
  task automatic test_min_clamp();
    int acc, t, e, o;
    int iv[8] = '{10, 7, 4, 2, 2, 5, 8, 10};
    obs_pulse_q.delete(); obs_done_q.delete();
    send(1'b1, 1'b0, 16'd8, 16'd0, acc);
    t = acc;
    foreach (iv[i]) begin t += iv[i]; exp_pulse_q.push_back(t); end
    exp_done_q.push_back(t + 1);
    wait_done(100);
    while (exp_pulse_q.size() > 0) begin
      e = exp_pulse_q.pop_front(); o = (obs_pulse_q.size() > 0) ? obs_pulse_q.pop_front() : -1;
      n_cmp++; if (o != e) begin n_bad++; $display("FAIL clamp_pulse: cycle %0d want %0d", o, e); end
    end
    while (exp_done_q.size() > 0) begin
      e = exp_done_q.pop_front(); o = (obs_done_q.size() > 0) ? obs_done_q.pop_front() : -1;
      n_cmp++; if (o != e) begin n_bad++; $display("FAIL clamp_done: cycle %0d want %0d", o, e); end
    end
    n_cmp++; if (obs_pulse_q.size() + obs_done_q.size() != 0) begin n_bad++; $display("FAIL clamp_extra: %0d extra events want 0", obs_pulse_q.size() + obs_done_q.size()); end
  endtask

  task automatic test_zero();
    int acc, e, o;
    obs_pulse_q.delete(); obs_done_q.delete();
    send(1'b1, 1'b0, 16'd0, 16'd7, acc);
    exp_done_q.push_back(acc + 1);
    n_cmp++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL zero_done: done %b busy %b want 1 0", bus.done, bus.busy); end
    n_cmp++; if (bus.direction !== 1'b1 || bus.step !== 1'b0) begin n_bad++; $display("FAIL zero_latch: dir %b step %b want 1 0", bus.direction, bus.step); end
    repeat (5) @(negedge clk);
    #1;
    while (exp_done_q.size() > 0) begin
      e = exp_done_q.pop_front(); o = (obs_done_q.size() > 0) ? obs_done_q.pop_front() : -1;
      n_cmp++; if (o != e) begin n_bad++; $display("FAIL zero_done_cycle: cycle %0d want %0d", o, e); end
    end
    n_cmp++; if (obs_pulse_q.size() + obs_done_q.size() != 0) begin n_bad++; $display("FAIL zero_extra: %0d extra events want 0", obs_pulse_q.size() + obs_done_q.size()); end
  endtask

  task automatic test_abort();
    int acc, t, e, o;
    int iv[5] = '{10, 7, 4, 4, 4};
    obs_pulse_q.delete(); obs_done_q.delete();
    send(1'b0, 1'b1, 16'd100, 16'd4, acc);
    t = acc;
    foreach (iv[i]) begin t += iv[i]; exp_pulse_q.push_back(t); end
    // Sixth strobe would fall 4 cycles after the fifth; abort lands on it.
    while (cyc < t + 4) begin @(posedge clk); #1; end
    bus.abort = 1'b1;
    #1;
    n_cmp++; if (bus.step_pulse !== 1'b0) begin n_bad++; $display("FAIL abort_suppress: pulse %b want 0", bus.step_pulse); end
    exp_done_q.push_back(t + 5);
    @(posedge clk); #1;
    bus.abort = 1'b0;
    n_cmp++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL abort_idle: done %b busy %b ready %b want 1 0 1", bus.done, bus.busy, bus.cmd_ready); end
    n_cmp++; if (bus.steps_left !== 16'd95) begin n_bad++; $display("FAIL abort_left: got %0d want 95", bus.steps_left); end
    repeat (20) @(posedge clk);
    #1 bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    n_cmp++; if (bus.done !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.steps_left !== 16'd95) begin n_bad++; $display("FAIL abort_in_idle: done %b ready %b left %0d want 0 1 95", bus.done, bus.cmd_ready, bus.steps_left); end
    repeat (3) @(negedge clk);
    #1;
    while (exp_pulse_q.size() > 0) begin
      e = exp_pulse_q.pop_front(); o = (obs_pulse_q.size() > 0) ? obs_pulse_q.pop_front() : -1;
      n_cmp++; if (o != e) begin n_bad++; $display("FAIL abort_pulse: cycle %0d want %0d", o, e); end
    end
    while (exp_done_q.size() > 0) begin
      e = exp_done_q.pop_front(); o = (obs_done_q.size() > 0) ? obs_done_q.pop_front() : -1;
      n_cmp++; if (o != e) begin n_bad++; $display("FAIL abort_done: cycle %0d want %0d", o, e); end
    end
    n_cmp++; if (obs_pulse_q.size() + obs_done_q.size() != 0) begin n_bad++; $display("FAIL abort_extra: %0d extra events want 0", obs_pulse_q.size() + obs_done_q.size()); end
  endtask

  task automatic test_back_to_back();
    int a0, a1, chg, e, o;
    obs_pulse_q.delete(); obs_done_q.delete();
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_dir = 1'b1; bus.cmd_full = 1'b1;
    bus.cmd_steps = 16'd2; bus.cmd_period = 16'd12;
    a0 = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.cmd_ready === 1'b1) begin a0 = cyc; break; end
    end
    @(posedge clk); #1;
    bus.cmd_dir = 1'b0; bus.cmd_full = 1'b0;
    bus.cmd_steps = 16'd1; bus.cmd_period = 16'd11;
    chg = 0; a1 = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.cmd_ready === 1'b1) begin a1 = cyc; break; end
      if (bus.direction !== 1'b1) chg++;
    end
    n_cmp++; if (a0 < 0 || a1 != a0 + 25) begin n_bad++; $display("FAIL b2b_accept: second accept cycle %0d want %0d", a1, a0 + 25); end
    n_cmp++; if (chg != 0) begin n_bad++; $display("FAIL b2b_dir_stable: %0d changed cycles want 0", chg); end
    n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL b2b_done_with_ready: done %b want 1", bus.done); end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    n_cmp++; if (bus.direction !== 1'b0 || bus.step !== 1'b0 || bus.busy !== 1'b1 || bus.steps_left !== 16'd1) begin n_bad++; $display("FAIL b2b_second: dir %b step %b busy %b left %0d want 0 0 1 1", bus.direction, bus.step, bus.busy, bus.steps_left); end
    exp_pulse_q.push_back(a0 + 12);
    exp_pulse_q.push_back(a0 + 24);
    exp_pulse_q.push_back(a1 + 11);
    exp_done_q.push_back(a0 + 25);
    exp_done_q.push_back(a1 + 12);
    wait_done(50);
    repeat (3) @(negedge clk);
    #1;
    while (exp_pulse_q.size() > 0) begin
      e = exp_pulse_q.pop_front(); o = (obs_pulse_q.size() > 0) ? obs_pulse_q.pop_front() : -1;
      n_cmp++; if (o != e) begin n_bad++; $display("FAIL b2b_pulse: cycle %0d want %0d", o, e); end
    end
    while (exp_done_q.size() > 0) begin
      e = exp_done_q.pop_front(); o = (obs_done_q.size() > 0) ? obs_done_q.pop_front() : -1;
      n_cmp++; if (o != e) begin n_bad++; $display("FAIL b2b_done: cycle %0d want %0d", o, e); end
    end
    n_cmp++; if (obs_pulse_q.size() + obs_done_q.size() != 0) begin n_bad++; $display("FAIL b2b_extra: %0d extra events want 0", obs_pulse_q.size() + obs_done_q.size()); end
  endtask

  task automatic test_reset_mid();
    int acc, t, e, o;
    int iv[6] = '{10, 7, 4, 4, 7, 10};
    obs_pulse_q.delete(); obs_done_q.delete();
    send(1'b1, 1'b1, 16'd3, 16'd12, acc);
    exp_pulse_q.push_back(acc + 12);
    while (cyc < acc + 15) begin @(posedge clk); #1; end
    nrst = 1'b0;
    #1;
    n_cmp++; if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b0 || bus.step_pulse !== 1'b0 || bus.done !== 1'b0) begin n_bad++; $display("FAIL rmid_ctrl: busy %b ready %b pulse %b done %b want 0 0 0 0", bus.busy, bus.cmd_ready, bus.step_pulse, bus.done); end
    n_cmp++; if (bus.direction !== 1'b0 || bus.step !== 1'b1 || bus.steps_left !== 16'd0) begin n_bad++; $display("FAIL rmid_latch: dir %b step %b left %0d want 0 1 0", bus.direction, bus.step, bus.steps_left); end
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;
    #1;
    n_cmp++; if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL rmid_release: ready %b busy %b want 1 0", bus.cmd_ready, bus.busy); end
    send(1'b0, 1'b0, 16'd6, 16'd4, acc);
    t = acc;
    foreach (iv[i]) begin t += iv[i]; exp_pulse_q.push_back(t); end
    exp_done_q.push_back(t + 1);
    wait_done(100);
    while (exp_pulse_q.size() > 0) begin
      e = exp_pulse_q.pop_front(); o = (obs_pulse_q.size() > 0) ? obs_pulse_q.pop_front() : -1;
      n_cmp++; if (o != e) begin n_bad++; $display("FAIL rmid_pulse: cycle %0d want %0d", o, e); end
    end
    while (exp_done_q.size() > 0) begin
      e = exp_done_q.pop_front(); o = (obs_done_q.size() > 0) ? obs_done_q.pop_front() : -1;
      n_cmp++; if (o != e) begin n_bad++; $display("FAIL rmid_done: cycle %0d want %0d", o, e); end
    end
    n_cmp++; if (obs_pulse_q.size() + obs_done_q.size() != 0) begin n_bad++; $display("FAIL rmid_extra: %0d extra events want 0", obs_pulse_q.size() + obs_done_q.size()); end
  endtask

  // Scenario sequence.
  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_dir    = 1'b0;
    bus.cmd_full   = 1'b0;
    bus.cmd_steps  = 16'd0;
    bus.cmd_period = 16'd0;
    bus.abort      = 1'b0;
    test_reset();
    test_cruise();
    test_trapezoid();
    test_triangle();
    test_min_clamp();
    test_zero();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #1000000;
    $display("FAIL watchdog: time %0t reached without finishing", $time);
    $fatal(1);
  end
endmodule

// File: doc/motor_move_ctrl.md
MOTOR_MOVE_CTRL -- requirements
Module: motor_move_ctrl

Interface
REQ-001 Parameter START_PERIOD, default 16'd1000, start/stop step interval in clk cycles.
REQ-002 Parameter ACCEL_DEC, default 16'd50, interval change per step while ramping.
REQ-003 Parameter MIN_PERIOD, default 16'd2, smallest permitted step interval.
REQ-004 clk  in  1  system clock, rising edge.
REQ-005 nrst  in  1  reset, asynchronous, active-low.
REQ-006 cmd_valid  in  1  move command offered.
REQ-007 cmd_ready  out  1  block can accept a command.
REQ-008 cmd_dir  in  1  direction, 1 = forward.
REQ-009 cmd_full  in  1  1 = full step, 0 = half step.
REQ-010 cmd_steps  in  16  number of step pulses to issue.
REQ-011 cmd_period  in  16  cruise interval in clk cycles.
REQ-012 abort  in  1  synchronous stop request.
REQ-013 step_pulse  out  1  one-cycle advance strobe to the downstream phase sequencer.
REQ-014 direction  out  1  latched cmd_dir.
REQ-015 step  out  1  latched cmd_full.
REQ-016 busy  out  1  move in progress.
REQ-017 done  out  1  one-cycle move-finished strobe.
REQ-018 steps_left  out  16  pulses remaining in the current or last move.

Function
REQ-019 States: IDLE, ACCEL, CRUISE, DECEL. cmd_ready SHALL be 1 only in IDLE. busy SHALL be 1 in every other state.
REQ-020 Accept on cmd_valid&&cmd_ready. Latch direction, step, steps_left=cmd_steps, and target=max(cmd_period, MIN_PERIOD).
REQ-021 On accept with cmd_steps=0, stay IDLE, pulse done next cycle, issue no step_pulse.
REQ-022 On accept, if target>=START_PERIOD: cur_period=target, go CRUISE. Otherwise cur_period=START_PERIOD, go ACCEL. Clear accel_steps.
REQ-023 Interval timer loads cur_period-1 on accept and on each pulse, then decrements every cycle. step_pulse=1 for exactly the cycle in which the timer is 0. The first pulse therefore comes cur_period cycles after the accept cycle.
REQ-024 On each pulse, steps_left decrements. Evaluate in priority order: (a) steps_left becomes 0 -> IDLE, done=1 next cycle; (b) decel check; (c) ramp update.
REQ-025 ACCEL pulse:
- accel_steps+1.
- Decel check: if new steps_left<=accel_steps -> DECEL, cur_period unchanged.
- Otherwise cur_period-=ACCEL_DEC. If the result is <=target, clamp to target and go CRUISE.
REQ-026 CRUISE pulse: if new steps_left<=accel_steps -> DECEL, with cur_period+=ACCEL_DEC and accel_steps-1.
REQ-027 DECEL pulse: cur_period+=ACCEL_DEC, saturating at START_PERIOD; accel_steps-1, saturating at 0.
REQ-028 Counters SHALL be 16-bit with no wrap: steps_left never goes below 0, and cur_period stays within [target, START_PERIOD] during ramps.
REQ-029 abort while busy: no further step_pulse (a pulse due in the same cycle is suppressed), go IDLE next cycle, done=1 that cycle, steps_left holds the remaining count. abort in IDLE is ignored.
REQ-030 A command offered while busy SHALL NOT be accepted. cmd_valid may stay high and is accepted in the first IDLE cycle, which is the same cycle done is high.
REQ-031 direction and step SHALL change only on accept and be stable throughout and after the move.

Reset
REQ-032 nrst low SHALL immediately force:
- state IDLE
- step_pulse=0, done=0, busy=0, cmd_ready=0 while nrst is low and 1 after release
- direction=0, step=1, steps_left=0
- timer, cur_period, accel_steps cleared
REQ-033 Reset mid-move SHALL discard the move with no pulse or done emitted.

Verification
REQ-034 Cruise-only: START_PERIOD=10, cmd_period=12, steps=3 accepted at cycle 0 -> pulses at 12,24,36; done at 37; busy 1..36.
REQ-035 Trapezoid: START_PERIOD=10, ACCEL_DEC=3, cmd_period=4, steps=6 -> pulse intervals 10,7,4,4,7,10; states ACCEL,ACCEL,CRUISE,CRUISE,DECEL,DECEL.
REQ-036 Triangle: same parameters, cmd_period=2, steps=4 -> intervals 10,7,7,10; CRUISE never entered.
REQ-037 Abort: steps=100, assert abort in the cycle a pulse is due after 5 pulses -> that pulse suppressed, done next cycle, steps_left=95, cmd_ready=1.
REQ-038 Zero/back-to-back: steps=0 -> done at cycle 1, no pulse. cmd_valid held high through a move -> second command accepted in the done cycle; direction updates only then.
REQ-039 Reset mid-move: nrst low during CRUISE -> outputs at reset values the same cycle. After release, a new command runs normally from START_PERIOD.
